// File: rtl/sfm_pkg.sv
// Shared types for the softmax state-slot interface: op codes, request and
// update records, the controller-side control bundle and the active slot.
package sfm_pkg;

    localparam int ADDR_W        = 16;
    localparam int MAX_W         = 16;
    localparam int DEN_W         = 32;
    localparam int SLOT_STRIDE_B = 8;

    typedef enum logic [1:0] {ALLOC, LOAD, UPDATE, FREE} slot_op_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        slot_op_e          op;
    } slot_req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        slot_op_e          op;
        logic [MAX_W-1:0]  maximum;
        logic [DEN_W-1:0]  denominator;
    } slot_update_t;

    typedef struct packed {
        logic [31:0]       cache_base_addr;
        logic [ADDR_W-1:0] addr;
        logic              req_valid;
        slot_req_t         req_op;
        logic              update_valid;
        slot_update_t      update_op;
    } slot_regfile_ctrl_t;

    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] maximum;
        logic [DEN_W-1:0] denominator;
    } slot_t;

    // Byte address of a slot's first word; wraps at 32 bits.
    function automatic logic [31:0] slot_base(input logic [31:0] cache_base,
                                              input logic [ADDR_W-1:0] addr);
        return cache_base + 32'(addr) * 32'(SLOT_STRIDE_B);
    endfunction

endpackage

// File: rtl/sfm_slot_req_fifo.sv
// Small synchronous FIFO. A push into a full FIFO is dropped and flagged on
// overflow unless a pop frees the slot in the same cycle. clear empties it
// and wins over a concurrent push.
module sfm_slot_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign do_pop   = pop && !empty && !clear;
    assign do_push  = push && !clear && (!full || do_pop);
    assign overflow = push && !clear && full && !do_pop;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sfm_slot_cache.sv
// Holds the single active softmax slot and moves slots to/from TCDM.
// Updates spill the slot (denominator then maximum), loads refill it, and
// ALLOC/FREE only touch the local copy. Memory outputs are registered and a
// raised request holds address/data/wen until granted.
module sfm_slot_cache
    import sfm_pkg::*;
#(
    parameter int               REQ_DEPTH = 2,
    parameter logic [MAX_W-1:0] ALLOC_MAX = 16'hFF80
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  slot_regfile_ctrl_t slot_ctrl_i,
    output slot_t              state_slot_o,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic               mem_wen_o,
    output logic [31:0]        mem_add_o,
    output logic [31:0]        mem_data_o,
    output logic [3:0]         mem_be_o,
    input  logic [31:0]        mem_r_data_i,
    input  logic               mem_r_valid_i,
    output logic               err_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD0    = 3'd1;
    localparam logic [2:0] RD1    = 3'd2;
    localparam logic [2:0] RDWAIT = 3'd3;
    localparam logic [2:0] WR0    = 3'd4;
    localparam logic [2:0] WR1    = 3'd5;
    localparam logic [2:0] DRAIN  = 3'd6;

    logic [2:0]       state;
    slot_req_t        head;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_ovf;
    slot_update_t     upd_q;
    logic             upd_vld;
    logic             upd_free;
    logic             upd_drop;
    logic [31:0]      cur_base;
    logic [MAX_W-1:0] cur_max;
    logic [DEN_W-1:0] cur_den;
    logic             rd_idx;
    logic [1:0]       outst;
    logic             xfer;
    logic             rd_gnt;
    logic             unused_ok;

    assign mem_be_o  = 4'hF;
    assign xfer      = mem_req_o && mem_gnt_i;
    assign rd_gnt    = xfer && mem_wen_o;
    // Pending update always wins arbitration over the FIFO head.
    assign fifo_pop  = (state == IDLE) && !clear_i && !upd_vld && !fifo_empty;
    assign upd_free  = !clear_i && (((state == IDLE) && upd_vld && (upd_q.op != UPDATE)) ||
                                    ((state == WR1) && xfer));
    assign upd_drop  = slot_ctrl_i.update_valid && upd_vld && !clear_i;
    assign unused_ok = ^{slot_ctrl_i.addr, mem_r_data_i[31:MAX_W], fifo_full};

    sfm_slot_req_fifo #(
        .WIDTH ($bits(slot_req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (clear_i),
        .push      (slot_ctrl_i.req_valid),
        .push_data (slot_ctrl_i.req_op),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf)
    );

    // Single-entry update holding register; a new update while occupied is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_vld <= 1'b0;
            upd_q   <= '0;
        end else if (clear_i || upd_free) begin
            upd_vld <= 1'b0;
        end else if (slot_ctrl_i.update_valid && !upd_vld) begin
            upd_vld <= 1'b1;
            upd_q   <= slot_ctrl_i.update_op;
        end
    end

    // Dropped-op pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) err_o <= 1'b0;
        else       err_o <= fifo_ovf || upd_drop;
    end

    // Outstanding read responses; a grant and a response may coincide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst <= 2'd0;
        end else begin
            case ({rd_gnt, mem_r_valid_i})
                2'b10:   outst <= outst + 2'd1;
                2'b01:   outst <= outst - 2'd1;
                default: ;
            endcase
        end
    end

    // Slot FSM: arbitration, memory handshakes and active-slot updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            state_slot_o <= '0;
            mem_req_o    <= 1'b0;
            mem_wen_o    <= 1'b1;
            mem_add_o    <= '0;
            mem_data_o   <= '0;
            cur_base     <= '0;
            cur_max      <= '0;
            cur_den      <= '0;
            rd_idx       <= 1'b0;
        end else if (clear_i) begin
            state_slot_o.valid <= 1'b0;
            rd_idx             <= 1'b0;
            if (state != IDLE) begin
                // An in-flight request must still complete its handshake.
                state <= DRAIN;
                if (xfer) begin
                    mem_req_o <= 1'b0;
                    mem_wen_o <= 1'b1;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (upd_vld) begin
                        state_slot_o.valid <= 1'b0;
                        if (upd_q.op == UPDATE) begin
                            cur_base <= slot_base(slot_ctrl_i.cache_base_addr, upd_q.addr);
                            cur_max  <= upd_q.maximum;
                            cur_den  <= upd_q.denominator;
                            state    <= WR0;
                        end
                    end else if (!fifo_empty) begin
                        if (head.op == ALLOC) begin
                            state_slot_o.valid       <= 1'b1;
                            state_slot_o.maximum     <= ALLOC_MAX;
                            state_slot_o.denominator <= '0;
                        end else if (head.op == LOAD) begin
                            state_slot_o.valid <= 1'b0;
                            cur_base <= slot_base(slot_ctrl_i.cache_base_addr, head.addr);
                            rd_idx   <= 1'b0;
                            state    <= RD0;
                        end
                    end
                end
                RD0: begin
                    if (!mem_req_o) begin
                        mem_req_o <= 1'b1;
                        mem_wen_o <= 1'b1;
                        mem_add_o <= cur_base;
                    end else if (mem_gnt_i) begin
                        mem_add_o <= cur_base + 32'd4;
                        state     <= RD1;
                    end
                end
                RD1: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= RDWAIT;
                    end
                    // Word0 response may already return alongside the word1 grant.
                    if (mem_r_valid_i) begin
                        state_slot_o.denominator <= mem_r_data_i;
                        rd_idx                   <= 1'b1;
                    end
                end
                RDWAIT: begin
                    if (mem_r_valid_i) begin
                        if (!rd_idx) begin
                            state_slot_o.denominator <= mem_r_data_i;
                            rd_idx                   <= 1'b1;
                        end else begin
                            state_slot_o.maximum <= mem_r_data_i[MAX_W-1:0];
                            state_slot_o.valid   <= 1'b1;
                            rd_idx               <= 1'b0;
                            state                <= IDLE;
                        end
                    end
                end
                WR0: begin
                    if (!mem_req_o) begin
                        mem_req_o  <= 1'b1;
                        mem_wen_o  <= 1'b0;
                        mem_add_o  <= cur_base;
                        mem_data_o <= cur_den;
                    end else if (mem_gnt_i) begin
                        mem_add_o  <= cur_base + 32'd4;
                        mem_data_o <= 32'(cur_max);
                        state      <= WR1;
                    end
                end
                WR1: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        mem_wen_o <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_req_o) begin
                        if (mem_gnt_i) begin
                            mem_req_o <= 1'b0;
                            mem_wen_o <= 1'b1;
                        end
                    end else if (outst == 2'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfm_slot_cache.sv
// Directed bench for sfm_slot_cache with a small TCDM model (grant stall and
// per-address read latency knobs) and a log of granted transfers.
module tb_sfm_slot_cache;
    import sfm_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    slot_regfile_ctrl_t ctrl;
    slot_t              slot;
    logic               mem_req;
    logic               mem_gnt;
    logic               mem_wen;
    logic [31:0]        mem_add;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_be;
    logic [31:0]        mem_rdata;
    logic               mem_rv;
    logic               err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sfm_slot_cache #(.REQ_DEPTH(2), .ALLOC_MAX(16'hFF80)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .slot_ctrl_i   (ctrl),
        .state_slot_o  (slot),
        .mem_req_o     (mem_req),
        .mem_gnt_i     (mem_gnt),
        .mem_wen_o     (mem_wen),
        .mem_add_o     (mem_add),
        .mem_data_o    (mem_wdata),
        .mem_be_o      (mem_be),
        .mem_r_data_i  (mem_rdata),
        .mem_r_valid_i (mem_rv),
        .err_o         (err)
    );

    // memory model
    bit   [31:0] mem [bit [31:0]];
    logic [31:0] stall_addr;
    int          stall_left;
    logic [31:0] slow_addr;
    int          slow_lat;
    logic [7:0]  rv_pipe = '0;
    logic [31:0] rd_pipe [8];
    int          req_cyc = 0;
    int          err_cnt = 0;
    logic        log_wen [$];
    logic [31:0] log_add [$];
    logic [31:0] log_dat [$];

    assign mem_gnt   = mem_req && !(mem_add == stall_addr && stall_left > 0);
    assign mem_rv    = rv_pipe[0];
    assign mem_rdata = rd_pipe[0];

    always @(posedge clk) begin
        int lat;
        rv_pipe <= {1'b0, rv_pipe[7:1]};
        for (int i = 0; i < 7; i++) rd_pipe[i] <= rd_pipe[i+1];
        rd_pipe[7] <= '0;
        if (mem_req) req_cyc <= req_cyc + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (mem_req && !mem_gnt) stall_left <= stall_left - 1;
        if (mem_req && mem_gnt) begin
            log_wen.push_back(mem_wen);
            log_add.push_back(mem_add);
            log_dat.push_back(mem_wdata);
            if (!mem_wen) begin
                mem[mem_add] = mem_wdata;
            end else begin
                lat = (mem_add == slow_addr) ? slow_lat : 1;
                rv_pipe[lat-1] <= 1'b1;
                rd_pipe[lat-1] <= mem.exists(mem_add) ? mem[mem_add] : 32'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        log_wen.delete();
        log_add.delete();
        log_dat.delete();
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!slot.valid && n < max) begin
            tick();
            n++;
        end
        chk(tag, slot.valid, 1'b1);
    endtask

    task automatic wait_log(input string tag, input int cnt, input int max);
        int n = 0;
        while (log_wen.size() < cnt && n < max) begin
            tick();
            n++;
        end
        chk(tag, log_wen.size(), cnt);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr, input int max);
        int n = 0;
        while (!(mem_req && mem_add == addr) && n < max) begin
            tick();
            n++;
        end
        chk(tag, mem_req && mem_add == addr, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int e0;
        rst = 1'b1; clear = 1'b0; ctrl = '0;
        stall_addr = '1; stall_left = 0; slow_addr = '1; slow_lat = 1;
        repeat (3) tick();
        chk("rst_slot", slot, '0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_wen", mem_wen, 1'b1);
        chk("rst_add", mem_add, 32'h0);
        chk("rst_dat", mem_wdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_be", mem_be, 4'hF);
        rst = 1'b0;
        ctrl.cache_base_addr = 32'h1000_0000;
        tick();

        // ALLOC addr 3: valid two cycles after the request, no memory traffic
        r0 = req_cyc;
        ctrl.req_valid = 1'b1; ctrl.req_op = '{addr: 16'd3, op: ALLOC};
        tick();
        ctrl.req_valid = 1'b0;
        chk("alloc_lat1", slot.valid, 1'b0);
        tick();
        chk("alloc_vld", slot.valid, 1'b1);
        chk("alloc_max", slot.maximum, 16'hFF80);
        chk("alloc_den", slot.denominator, 32'h0);
        chk("alloc_nomem", req_cyc - r0, 0);

        // UPDATE addr 2 spills den then max
        clr_log();
        ctrl.update_valid = 1'b1;
        ctrl.update_op = '{addr: 16'd2, op: UPDATE, maximum: 16'h3F80, denominator: 32'h4000_0000};
        tick();
        ctrl.update_valid = 1'b0;
        tick();
        chk("upd_clr_vld", slot.valid, 1'b0);
        wait_log("upd_nwr", 2, 20);
        chk("upd_w0", {log_wen[0], log_add[0], log_dat[0]}, {1'b0, 32'h1000_0010, 32'h4000_0000});
        chk("upd_w1", {log_wen[1], log_add[1], log_dat[1]}, {1'b0, 32'h1000_0014, 32'h0000_3F80});
        repeat (2) tick();

        // LOAD addr 2 with zero-wait memory: valid 6 cycles after request
        clr_log();
        ctrl.req_valid = 1'b1; ctrl.req_op = '{addr: 16'd2, op: LOAD};
        tick();
        ctrl.req_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            chk("ld_early", slot.valid, 1'b0);
            tick();
        end
        chk("ld_lat5", slot.valid, 1'b0);
        tick();
        chk("ld_lat6", slot.valid, 1'b1);
        chk("ld_max", slot.maximum, 16'h3F80);
        chk("ld_den", slot.denominator, 32'h4000_0000);
        chk("ld_rd0", {log_wen[0], log_add[0]}, {1'b1, 32'h1000_0010});
        chk("ld_rd1", {log_wen[1], log_add[1]}, {1'b1, 32'h1000_0014});

        // LOAD with word1 grant stalled 5 cycles; three ALLOCs pushed meanwhile
        clr_log();
        e0 = err_cnt;
        stall_addr = 32'h1000_0014; stall_left = 5;
        ctrl.req_valid = 1'b1; ctrl.req_op = '{addr: 16'd2, op: LOAD};
        tick();
        ctrl.req_valid = 1'b0;
        wait_req("stl_seen", 32'h1000_0014, 20);
        for (int i = 0; i < 5; i++) begin
            chk("stl_req", mem_req, 1'b1);
            chk("stl_add", mem_add, 32'h1000_0014);
            chk("stl_wen", mem_wen, 1'b1);
            chk("stl_vld", slot.valid, 1'b0);
            if (i < 3) begin
                ctrl.req_valid = 1'b1;
                ctrl.req_op = '{addr: 16'(5 + i), op: ALLOC};
            end else begin
                ctrl.req_valid = 1'b0;
            end
            tick();
        end
        ctrl.req_valid = 1'b0;
        wait_valid("stl_done", 10);
        chk("stl_max", slot.maximum, 16'h3F80);
        chk("stl_den", slot.denominator, 32'h4000_0000);
        chk("ovf_err_once", err_cnt - e0, 1);
        tick();
        chk("q_alloc0", {slot.valid, slot.maximum, slot.denominator}, {1'b1, 16'hFF80, 32'h0});
        tick();
        chk("q_alloc1", {slot.valid, slot.maximum, slot.denominator}, {1'b1, 16'hFF80, 32'h0});
        stall_left = 0;
        repeat (2) tick();

        // UPDATE and LOAD of slot 9 in the same cycle: writes first
        clr_log();
        ctrl.update_valid = 1'b1;
        ctrl.update_op = '{addr: 16'd9, op: UPDATE, maximum: 16'h1234, denominator: 32'hCAFE_F00D};
        ctrl.req_valid = 1'b1; ctrl.req_op = '{addr: 16'd9, op: LOAD};
        tick();
        ctrl.update_valid = 1'b0; ctrl.req_valid = 1'b0;
        tick();
        chk("ul_clr", slot.valid, 1'b0);
        wait_valid("ul_vld", 30);
        chk("ul_n", log_wen.size(), 4);
        chk("ul_o0", {log_wen[0], log_add[0]}, {1'b0, 32'h1000_0048});
        chk("ul_o1", {log_wen[1], log_add[1]}, {1'b0, 32'h1000_004C});
        chk("ul_o2", {log_wen[2], log_add[2]}, {1'b1, 32'h1000_0048});
        chk("ul_o3", {log_wen[3], log_add[3]}, {1'b1, 32'h1000_004C});
        chk("ul_max", slot.maximum, 16'h1234);
        chk("ul_den", slot.denominator, 32'hCAFE_F00D);
        repeat (2) tick();

        // clear during RDWAIT with the word1 response still outstanding
        clr_log();
        slow_addr = 32'h1000_0014; slow_lat = 4;
        ctrl.req_valid = 1'b1; ctrl.req_op = '{addr: 16'd2, op: LOAD};
        tick();
        ctrl.req_valid = 1'b0;
        wait_req("clr_seen", 32'h1000_0010, 20);
        repeat (2) tick();
        chk("clr_pre_req", mem_req, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("clr_vld", slot.valid, 1'b0);
            chk("clr_noreq", mem_req, 1'b0);
            tick();
        end
        chk("clr_nlog", log_wen.size(), 2);
        slow_lat = 1;
        ctrl.req_valid = 1'b1; ctrl.req_op = '{addr: 16'd1, op: ALLOC};
        tick();
        ctrl.req_valid = 1'b0;
        chk("clr_alloc_lat1", slot.valid, 1'b0);
        tick();
        chk("clr_alloc", {slot.valid, slot.maximum, slot.denominator}, {1'b1, 16'hFF80, 32'h0});

        // FREE clears valid with no memory traffic
        r0 = req_cyc;
        ctrl.update_valid = 1'b1;
        ctrl.update_op = '{addr: 16'd1, op: FREE, maximum: 16'h0, denominator: 32'h0};
        tick();
        ctrl.update_valid = 1'b0;
        tick();
        chk("free_vld", slot.valid, 1'b0);
        repeat (3) tick();
        chk("free_nomem", req_cyc - r0, 0);

        // slot address wraps at 32 bits
        clr_log();
        ctrl.cache_base_addr = 32'hFFFF_FFF4;
        ctrl.update_valid = 1'b1;
        ctrl.update_op = '{addr: 16'd1, op: UPDATE, maximum: 16'h00AA, denominator: 32'h1111_2222};
        tick();
        ctrl.update_valid = 1'b0;
        wait_log("wrap_nwr", 2, 20);
        chk("wrap_w0", {log_add[0], log_dat[0]}, {32'hFFFF_FFFC, 32'h1111_2222});
        chk("wrap_w1", {log_add[1], log_dat[1]}, {32'h0000_0000, 32'h0000_00AA});
        repeat (2) tick();
        chk("err_total", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
